// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int BYTE_ADDR_SHIFT = 2;

endpackage

// File: rtl/imem_byte_assembler.sv
// Collects stream bytes into a big-endian 32-bit word; wordFull flags the
// cycle in which the fourth byte of a word is being accepted.
module imem_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        wordFull
);

  logic [1:0] byteCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      word    <= '0;
      byteCnt <= '0;
    end else if (clear) begin
      byteCnt <= '0;
    end else if (accept) begin
      // Shifting left leaves the first byte of the word in [31:24].
      word    <= {word[23:0], byteIn};
      byteCnt <= byteCnt + 2'd1;
    end
  end

  assign wordFull = accept && (byteCnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory and holds the CPU until the load is done.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE = 1;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] wordIdx;
  logic [ADDR_W:0]   lenLat;
  logic              idleLike;
  logic              startLoad;
  logic              byteAccept;
  logic              wordFull;
  logic              lastWord;

  assign idleLike   = (state == IDLE) || (state == DONE);
  assign startLoad  = start && idleLike && (len != '0) && (len <= MAX_LEN);
  assign byteAccept = (state == RECV) && s_valid && s_ready;
  assign lastWord   = ({1'b0, wordIdx} == (lenLat - LEN_ONE));

  imem_byte_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clear    (startLoad),
    .accept   (byteAccept),
    .byteIn   (s_data),
    .word     (mem_wdata),
    .wordFull (wordFull)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xorAcc;

  always_ff @(posedge clk) begin
    if (rst || startLoad) begin
      xorAcc <= '0;
    end else if (byteAccept) begin
      xorAcc <= xorAcc ^ s_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wordIdx  <= '0;
      lenLat   <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (len == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b0;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end else if (len > MAX_LEN) begin
              state    <= IDLE;
              err      <= 1'b1;
              done     <= 1'b0;
              cpu_hold <= 1'b1;
            end else begin
              state    <= RECV;
              lenLat   <= len;
              wordIdx  <= '0;
              done     <= 1'b0;
              err      <= 1'b0;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
              s_ready  <= 1'b1;
            end
          end
        end
        RECV: begin
          if (wordFull) begin
            state    <= WRITE;
            s_ready  <= 1'b0;
            mem_we   <= 1'b1;
            mem_addr <= 32'(wordIdx) << BYTE_ADDR_SHIFT;
          end
        end
        WRITE: begin
          if (lastWord) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state   <= CHECK;
            s_ready <= 1'b1;
`else
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state   <= RECV;
            wordIdx <= wordIdx + IDX_ONE;
            s_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (s_valid && s_ready) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (s_data == xorAcc) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= IDLE;
              err      <= 1'b1;
              done     <= 1'b0;
              cpu_hold <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader; expected words are rebuilt from the byte
// stream (and its XOR when IMEM_LOADER_CHECKSUM_EN is defined).
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = '0;
  logic              s_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0]       mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  logic [7:0]  stim[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      wrAddrQ.push_back(mem_addr);
      wrDataQ.push_back(mem_data_snapshot());
    end
  end

  function automatic logic [31:0] mem_data_snapshot();
    return mem_wdata;
  endfunction

  function automatic logic [7:0] stimXor();
    logic [7:0] x = '0;
    foreach (stim[i]) x ^= stim[i];
    return x;
  endfunction

  task automatic pulseStart(input logic [ADDR_W:0] l);
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b1;
    len     = l;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int gap;
    bit got;
    gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
    got = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = 8'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    for (int k = 0; k < 40; k++) begin
      if (s_ready) begin
        @(posedge clk);
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL sendByte: s_ready stayed 0 for 40 cycles, required 1");
    end
  endtask

  task automatic waitDone(input int bound);
    bit seen = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done || err) begin
        seen = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    checks++;
    if (!seen || !done || err) begin
      errors++;
      $display("FAIL waitDone: done=%0b err=%0b, required done=1 err=0", done, err);
    end
  endtask

  task automatic checkWrites(input int n);
    logic [31:0] expData;
    checks++;
    if (wrAddrQ.size() != n) begin
      errors++;
      $display("FAIL writeCount: got %0d writes, required %0d", wrAddrQ.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        expData = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
        checks++;
        if (wrAddrQ[i] !== 32'(i * 4) || wrDataQ[i] !== expData) begin
          errors++;
          $display("FAIL write[%0d]: got addr=%h data=%h, required addr=%h data=%h",
                   i, wrAddrQ[i], wrDataQ[i], 32'(i * 4), expData);
        end
      end
    end
  endtask

  task automatic loadStim(input int n, input int maxGap);
    wrAddrQ.delete();
    wrDataQ.delete();
    pulseStart((ADDR_W+1)'(n));
    foreach (stim[i]) sendByte(stim[i], maxGap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(stimXor(), maxGap);
`endif
    waitDone(12 * n + 50);
    checkWrites(n);
  endtask

  task automatic runLoad(input int n, input int maxGap);
    stim.delete();
    for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
    loadStim(n, maxGap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({cpu_hold, done, err, s_ready, mem_we, busy} !== 6'b100000) begin
        errors++;
        $display("FAIL resetIdle[%0d]: hold/done/err/rdy/we/busy=%b, required 100000", c,
                 {cpu_hold, done, err, s_ready, mem_we, busy});
      end
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL resetMem: addr=%h wdata=%h, required 0 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_basic();
    stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    wrAddrQ.delete();
    wrDataQ.delete();
    pulseStart(9'd2);
    for (int i = 0; i < 8; i++) begin
      sendByte(stim[i], 0);
      if (i % 4 == 3) begin
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || s_ready !== 1'b0) begin
          errors++;
          $display("FAIL basicWriteCycle[%0d]: mem_we=%0b s_ready=%0b, required 1 0", i / 4, mem_we, s_ready);
        end
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(stimXor(), 0);
    waitDone(10);
`else
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basicDone: done=%0b cpu_hold=%0b busy=%0b, required 1 0 0", done, cpu_hold, busy);
    end
`endif
    checkWrites(2);
  endtask

  task automatic test_gaps();
    runLoad(3, 3);
    for (int r = 0; r < 6; r++) runLoad(int'($urandom_range(5, 1)), 4);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) runLoad(int'($urandom_range(6, 1)), 0);
  endtask

  task automatic test_oversize();
    pulseStart(9'd257);
    checks++;
    if ({err, cpu_hold, done, busy, s_ready} !== 5'b11000) begin
      errors++;
      $display("FAIL oversize: err/hold/done/busy/rdy=%b, required 11000", {err, cpu_hold, done, busy, s_ready});
    end
  endtask

  task automatic test_len_zero();
    wrAddrQ.delete();
    pulseStart(9'd0);
    checks++;
    if ({done, err, busy, cpu_hold} !== 4'b1000) begin
      errors++;
      $display("FAIL lenZero: done/err/busy/hold=%b, required 1000", {done, err, busy, cpu_hold});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wrAddrQ.size() != 0) begin
      errors++;
      $display("FAIL lenZeroWrites: got %0d writes, required 0", wrAddrQ.size());
    end
  endtask

  task automatic test_start_busy();
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    wrAddrQ.delete();
    wrDataQ.delete();
    pulseStart(9'd2);
    sendByte(stim[0], 0);
    sendByte(stim[1], 0);
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b1;
    len     = 9'd1;
    @(negedge clk);
    start   = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL startBusy: busy=%0b done=%0b, required 1 0", busy, done);
    end
    for (int i = 2; i < 8; i++) sendByte(stim[i], 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    sendByte(stimXor(), 0);
`endif
    waitDone(60);
    checkWrites(2);
  endtask

  task automatic test_reset_mid();
    pulseStart(9'd4);
    for (int i = 0; i < 6; i++) sendByte(8'($urandom), 0);
    @(negedge clk);
    s_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    checks++;
    if ({s_ready, mem_we, cpu_hold, busy, done, err} !== 6'b001000 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL resetMid: rdy/we/hold/busy/done/err=%b addr=%h wdata=%h, required 001000 0 0",
               {s_ready, mem_we, cpu_hold, busy, done, err}, mem_addr, mem_wdata);
    end
    runLoad(2, 1);
  endtask

  task automatic test_full_capacity();
    runLoad(1 << ADDR_W, 0);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    pulseStart(9'd1);
    foreach (stim[i]) sendByte(stim[i], 0);
    sendByte(8'h04, 0);
    waitDone(10);
    pulseStart(9'd1);
    foreach (stim[i]) sendByte(stim[i], 0);
    sendByte(8'h05, 0);
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({err, done, cpu_hold, busy} !== 4'b1010) begin
      errors++;
      $display("FAIL checksumBad: err/done/hold/busy=%b, required 1010", {err, done, cpu_hold, busy});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_oversize();
    test_len_zero();
    test_start_busy();
    test_reset_mid();
    test_full_capacity();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
